adder3: RTL and testbench



---
 rtl/adder3.sv | 64 ++++++
 tb/tb_adder3.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder3.sv
// adder3: registered unsigned adder, a + b + cin -> WIDTH+1 bit sum.
// A combinational ripple-carry chain feeds a single output register stage;
// out_valid marks the cycle right after an accepted operand set.
module adder3 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  // Carry chain: carryChain[0] is the carry-in, carryChain[WIDTH] the carry-out.
  logic [WIDTH:0]   carryChain;
  logic [WIDTH-1:0] cellSum;
  logic [WIDTH:0]   rippleSum;

  logic [WIDTH:0]   sum_q;
  logic [WIDTH:0]   sum_d;
  logic             valid_q;
  logic             valid_d;

  assign carryChain[0] = cin;

  // One full-adder cell per operand bit, each feeding its carry to the next.
  for (genvar i = 0; i < WIDTH; i++) begin : gFullAdder
    logic halfSum;
    assign halfSum          = a[i] ^ b[i];
    assign cellSum[i]       = halfSum ^ carryChain[i];
    assign carryChain[i+1]  = (a[i] & b[i]) | (carryChain[i] & halfSum);
  end

  // The carry-out becomes the MSB, so the full range fits without wrapping.
  assign rippleSum = {carryChain[WIDTH], cellSum};

  // Next-state: load the new sum only on accept so idle-cycle operands,
  // including unknown ones, never reach the register.
  always_comb begin
    sum_d   = sum_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d = rippleSum;
    end
  end

  // Output register; reset clears the result and any in-flight accept at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder3.sv
// tb_adder3: self-checking bench for adder3 with WIDTH=3.
// Expected sums come from plain integer arithmetic and a queue of pending results.
module tb_adder3;

  localparam int WIDTH = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             out_valid;

  int errors = 0;
  int checks = 0;

  adder3 #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .cin(cin),
    .sum(sum),
    .out_valid(out_valid)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference result: the arithmetic sum, which always fits in WIDTH+1 bits.
  function automatic logic [WIDTH:0] refSum(input int ia, input int ib, input int ic);
    int total;
    total = ia + ib + ic;
    return total[WIDTH:0];
  endfunction

  // Drive one operand set on the falling edge, well clear of the sampling edge.
  task automatic applyStimulus(input logic v, input int ia, input int ib, input int ic);
    @(negedge clk);
    in_valid = v;
    a        = ia[WIDTH-1:0];
    b        = ib[WIDTH-1:0];
    cin      = ic[0];
  endtask

  // Advance past the next rising edge and settle before observing outputs.
  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (sum !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_initial: sum=%b out_valid=%b, want 0000/0", sum, out_valid);
    end
    applyStimulus(1'b0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 5, 6, 0);
    waitEdge();
    checks++;
    if (sum !== 4'b1011 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_preload: sum=%b out_valid=%b, want 1011/1", sum, out_valid);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: sum=%b out_valid=%b, want 0000/0", sum, out_valid);
    end
    // An accept presented while in reset must be discarded.
    waitEdge();
    checks++;
    if (sum !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: sum=%b out_valid=%b, want 0000/0", sum, out_valid);
    end
    applyStimulus(1'b0, 7, 7, 1);
    rst_n = 1'b1;
    waitEdge();
    checks++;
    if (sum !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: sum=%b out_valid=%b, want 0000/0", sum, out_valid);
    end
  endtask

  task automatic test_basic();
    int vecA[3]   = '{0, 1, 6};
    int vecB[3]   = '{0, 2, 5};
    logic [3:0] vecS[3] = '{4'b0000, 4'b0011, 4'b1011};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, vecA[i], vecB[i], 0);
      waitEdge();
      checks++;
      if (sum !== vecS[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_%0d: sum=%b out_valid=%b, want %b/1", i, sum, out_valid, vecS[i]);
      end
    end
  endtask

  task automatic test_carry_max();
    applyStimulus(1'b1, 7, 7, 1);
    waitEdge();
    checks++;
    if (sum !== 4'b1111 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL carry_max: sum=%b out_valid=%b, want 1111/1", sum, out_valid);
    end
    applyStimulus(1'b1, 0, 0, 1);
    waitEdge();
    checks++;
    if (sum !== 4'b0001 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL carry_in_only: sum=%b out_valid=%b, want 0001/1", sum, out_valid);
    end
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 3, 3, 0);
    waitEdge();
    checks++;
    if (sum !== 4'b0110 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_load: sum=%b out_valid=%b, want 0110/1", sum, out_valid);
    end
    applyStimulus(1'b0, 7, 7, 0);
    waitEdge();
    checks++;
    if (sum !== 4'b0110 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_idle: sum=%b out_valid=%b, want 0110/0", sum, out_valid);
    end
    // Operand wiggles between edges must not reach the output.
    a   = 3'b101;
    cin = 1'b1;
    #2;
    checks++;
    if (sum !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL hold_between_edges: sum=%b, want 0110", sum);
    end
  endtask

  task automatic test_back_to_back();
    int vecA[4] = '{1, 2, 4, 7};
    int vecB[4] = '{1, 3, 4, 0};
    logic [3:0] vecS[4] = '{4'b0010, 4'b0101, 4'b1000, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vecA[i], vecB[i], 0);
      waitEdge();
      checks++;
      if (sum !== vecS[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back_%0d: sum=%b out_valid=%b, want %b/1", i, sum, out_valid, vecS[i]);
      end
    end
    applyStimulus(1'b0, 0, 0, 0);
    waitEdge();
    checks++;
    if (out_valid !== 1'b0 || sum !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL back_to_back_drain: sum=%b out_valid=%b, want 0111/0", sum, out_valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [WIDTH:0] expQ[$];
    logic [WIDTH:0] expected;
    int  idx      = 0;
    int  cycles   = 0;
    int  accepts  = 0;
    int  pulses   = 0;
    bit  doAccept;
    while (idx < 128 && cycles < 2000) begin
      doAccept = ($urandom_range(0, 2) != 0);
      if (doAccept) begin
        applyStimulus(1'b1, idx % 8, (idx / 8) % 8, idx / 64);
        expQ.push_back(refSum(idx % 8, (idx / 8) % 8, idx / 64));
        accepts++;
        idx++;
      end else begin
        applyStimulus(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 1)));
      end
      waitEdge();
      cycles++;
      checks++;
      if (out_valid !== doAccept) begin
        errors++;
        $display("[TB] FAIL exh_valid cycle %0d: out_valid=%b, want %b", cycles, out_valid, doAccept);
      end
      if (out_valid === 1'b1) begin
        pulses++;
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL exh_spurious cycle %0d: sum=%b, want no pulse", cycles, sum);
        end else begin
          expected = expQ.pop_front();
          if (sum !== expected) begin
            errors++;
            $display("[TB] FAIL exh_sum cycle %0d: sum=%b, want %b", cycles, sum, expected);
          end
        end
      end
    end
    applyStimulus(1'b0, 0, 0, 0);
    waitEdge();
    checks++;
    if (idx != 128) begin
      errors++;
      $display("[TB] FAIL exh_budget: covered %0d combinations, want 128", idx);
    end
    checks++;
    if (pulses != accepts || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL exh_count: pulses=%0d pending=%0d, want %0d/0", pulses, expQ.size(), accepts);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_carry_max();
    test_hold();
    test_back_to_back();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
